// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, compare-flag bit positions and
// the output-register state type used by alu_share_arbiter.
package alu_pkg;

   localparam logic [3:0] ALU_ADD    = 4'h0;
   localparam logic [3:0] ALU_SUB    = 4'h1;
   localparam logic [3:0] ALU_SLL    = 4'h2;
   localparam logic [3:0] ALU_SLT    = 4'h3;
   localparam logic [3:0] ALU_SLTU   = 4'h4;
   localparam logic [3:0] ALU_XOR    = 4'h5;
   localparam logic [3:0] ALU_SRL    = 4'h6;
   localparam logic [3:0] ALU_SRA    = 4'h7;
   localparam logic [3:0] ALU_OR     = 4'h8;
   localparam logic [3:0] ALU_AND    = 4'h9;
   localparam logic [3:0] ALU_OP_MAX = 4'h9;

   // Flag vector is {greater, lesser, equal, greater_u, lesser_u}
   localparam int FLG_LTU = 0;
   localparam int FLG_GTU = 1;
   localparam int FLG_EQ  = 2;
   localparam int FLG_LT  = 3;
   localparam int FLG_GT  = 4;
   localparam int FLG_W   = 5;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU shared by all requesters. Compare flags always
// reflect in1 versus in2; illegal opcodes yield result 0 with err set.
module alu_core
   import alu_pkg::*;
(
   input  logic [3:0]       ctrl,
   input  logic [31:0]      in1,
   input  logic [31:0]      in2,
   output logic [31:0]      result,
   output logic [FLG_W-1:0] flags,
   output logic             err
);

   logic [4:0] shamt;
   assign shamt = in2[4:0];

   always_comb begin
      result = '0;
      case (ctrl)
         ALU_ADD:  result = in1 + in2;
         ALU_SUB:  result = in1 - in2;
         ALU_SLL:  result = in1 << shamt;
         ALU_SLT:  result = {31'd0, $signed(in1) < $signed(in2)};
         ALU_SLTU: result = {31'd0, in1 < in2};
         ALU_XOR:  result = in1 ^ in2;
         ALU_SRL:  result = in1 >> shamt;
         ALU_SRA:  result = $unsigned($signed(in1) >>> shamt);
         ALU_OR:   result = in1 | in2;
         ALU_AND:  result = in1 & in2;
         default:  result = '0;
      endcase
   end

   always_comb begin
      flags          = '0;
      flags[FLG_GT]  = $signed(in1) > $signed(in2);
      flags[FLG_LT]  = $signed(in1) < $signed(in2);
      flags[FLG_EQ]  = in1 == in2;
      flags[FLG_GTU] = in1 > in2;
      flags[FLG_LTU] = in1 < in2;
   end

   assign err = ctrl > ALU_OP_MAX;

endmodule

// File: rtl/alu_rr_picker.sv
// Picks the first valid requester starting at ptr and wrapping modulo
// NUM_REQ; returns a one-hot grant, its index and whether anything was valid.
module alu_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   always_comb begin
      int cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (!any && valid[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin grant and a
// one-entry valid/ready output register. Define ALU_ARB_FIXED_PRIO_EN for
// lowest-index-wins priority instead of round-robin.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [4*NUM_REQ-1:0]    req_ctrl,
   input  logic [32*NUM_REQ-1:0]   req_in1,
   input  logic [32*NUM_REQ-1:0]   req_in2,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             rsp_data,
   output logic [FLG_W-1:0]        rsp_flags,
   output logic                    rsp_err
);

   out_state_e         state;
   out_state_e         state_next;
   logic               can_accept;
   logic               accept;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_any;
   logic [ID_W-1:0]    pick_ptr;
   logic [3:0]         alu_ctrl;
   logic [31:0]        alu_in1;
   logic [31:0]        alu_in2;
   logic [31:0]        alu_result;
   logic [FLG_W-1:0]   alu_flags;
   logic               alu_err;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign pick_ptr = '0;
`else
   logic [ID_W-1:0] rr_ptr;

   // Pointer moves just past the winner so it has lowest priority next time
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   assign pick_ptr = rr_ptr;
`endif

   alu_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .valid (req_valid),
      .ptr   (pick_ptr),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   assign alu_ctrl = req_ctrl[grant_idx*4 +: 4];
   assign alu_in1  = req_in1[grant_idx*32 +: 32];
   assign alu_in2  = req_in2[grant_idx*32 +: 32];

   alu_core u_alu (
      .ctrl   (alu_ctrl),
      .in1    (alu_in1),
      .in2    (alu_in2),
      .result (alu_result),
      .flags  (alu_flags),
      .err    (alu_err)
   );

   // A full register can still take a new result when it drains this cycle
   assign can_accept = rst_n && ((state == OUT_EMPTY) || rsp_ready);
   assign req_ready  = can_accept ? grant : '0;
   assign accept     = can_accept && grant_any;
   assign rsp_valid  = (state == OUT_FULL);

   always_comb begin
      state_next = state;
      case (state)
         OUT_EMPTY: if (accept) state_next = OUT_FULL;
         OUT_FULL: begin
            if (accept)         state_next = OUT_FULL;
            else if (rsp_ready) state_next = OUT_EMPTY;
         end
         default:   state_next = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= OUT_EMPTY;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            rsp_id    <= grant_idx;
            rsp_data  <= alu_result;
            rsp_flags <= alu_flags;
            rsp_err   <= alu_err;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed corner cases plus a
// randomized run against a behavioural model. Honors ALU_ARB_FIXED_PRIO_EN.
module tb_alu_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [4*NUM_REQ-1:0]  req_ctrl;
   logic [32*NUM_REQ-1:0] req_in1;
   logic [32*NUM_REQ-1:0] req_in2;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_data;
   logic [4:0]            rsp_flags;
   logic                  rsp_err;

   int check_count = 0;
   int pass_count  = 0;

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   always #5 clk = ~clk;

   alu_share_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ctrl  (req_ctrl),
      .req_in1   (req_in1),
      .req_in2   (req_in2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_flags (rsp_flags),
      .rsp_err   (rsp_err)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
   endtask

   // Reference ALU written from the opcode table
   function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a << sh;
         4'h3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'h4: return (a < b) ? 32'd1 : 32'd0;
         4'h5: return a ^ b;
         4'h6: return a >> sh;
         4'h7: return $unsigned($signed(a) >>> sh);
         4'h8: return a | b;
         4'h9: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [4:0] model_flags(input logic [31:0] a, input logic [31:0] b);
      return {$signed(a) > $signed(b), $signed(a) < $signed(b), a == b, a > b, a < b};
   endfunction

   function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // Behavioural model state: contents of the output register and the pointer
   bit          m_valid = 1'b0;
   int          m_id    = 0;
   logic [31:0] m_data  = '0;
   logic [4:0]  m_flags = '0;
   bit          m_err   = 1'b0;
   int          m_ptr   = 0;

   always @(negedge clk) begin : compare
      int                 g;
      bit                 can;
      logic [NUM_REQ-1:0] exp_ready;
      logic [3:0]         op;
      logic [31:0]        a;
      logic [31:0]        b;
      can       = !m_valid || rsp_ready;
      g         = model_pick(req_valid, m_ptr);
      exp_ready = '0;
      if (rst_n && can && g >= 0) exp_ready[g] = 1'b1;
      checkOutput("req_ready", req_ready, exp_ready);
      checkOutput("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
         checkOutput("rsp_id", rsp_id, m_id);
         checkOutput("rsp_data", rsp_data, m_data);
         checkOutput("rsp_flags", rsp_flags, m_flags);
         checkOutput("rsp_err", rsp_err, m_err);
      end
      if (!rst_n) begin
         m_valid = 1'b0; m_id = 0; m_data = '0; m_flags = '0; m_err = 1'b0; m_ptr = 0;
      end else if (exp_ready != '0) begin
         op      = req_ctrl[g*4 +: 4];
         a       = req_in1[g*32 +: 32];
         b       = req_in2[g*32 +: 32];
         m_valid = 1'b1;
         m_id    = g;
         m_data  = model_result(op, a, b);
         m_flags = model_flags(a, b);
         m_err   = op > 4'h9;
         if (!FIXED) m_ptr = (g + 1) % NUM_REQ;
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
   end

   task automatic driveReq(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      req_ctrl[i*4 +: 4]  = op;
      req_in1[i*32 +: 32] = a;
      req_in2[i*32 +: 32] = b;
   endtask

   task automatic runSingle(input int i, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_data,
                            input logic exp_err);
      @(posedge clk); #1;
      req_valid    = '0;
      driveReq(i, op, a, b);
      req_valid[i] = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      checkOutput("single_valid", rsp_valid, 1);
      checkOutput("single_id", rsp_id, i);
      checkOutput("single_data", rsp_data, exp_data);
      checkOutput("single_err", rsp_err, exp_err);
   endtask

   // Random requesters that keep an unaccepted request stable
   task automatic applyStimulus(input int cycles);
      logic [NUM_REQ-1:0] acc;
      logic [31:0]        a;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || acc[i]) begin
               a = $urandom;
               if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 8);
               driveReq(i, 4'($urandom_range(0, 15)), a,
                        ($urandom_range(0, 3) == 0) ? a : 32'($urandom));
               req_valid[i] = ($urandom_range(0, 1) == 1);
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 63) != 0);
      end
   endtask

   initial begin
      logic [31:0] held_data;
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '1;
      req_ctrl  = '0;
      req_in1   = '0;
      req_in2   = '0;
      for (int i = 0; i < NUM_REQ; i++) driveReq(i, 4'h0, 32'(i), 32'(i));

      // Reset held with every requester asking
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ready", req_ready, 0);
      checkOutput("reset_valid", rsp_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("first_grant", req_ready, 4'b0001);

      // Single subtract from requester 1
      runSingle(1, 4'h1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
      checkOutput("sub_flags", rsp_flags, 5'b01001);

      // Fairness with all requesters valid (pointer now at 2)
      @(posedge clk); #1;
      req_valid = '1;
      for (int i = 0; i < NUM_REQ; i++) driveReq(i, 4'h0, 32'(i), 32'(i));
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("fair_valid", rsp_valid, 1);
         checkOutput("fair_id", rsp_id, FIXED ? 0 : (2 + k) % NUM_REQ);
      end

      // Back-pressure: the result accepted at this edge must be held
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      held_data = FIXED ? 32'd0 : 32'd4;
      repeat (5) begin
         @(negedge clk);
         checkOutput("stall_ready", req_ready, 0);
         checkOutput("stall_valid", rsp_valid, 1);
         checkOutput("stall_id", rsp_id, FIXED ? 0 : 2);
         checkOutput("stall_data", rsp_data, held_data);
         @(posedge clk);
      end
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("drain_ready", req_ready, FIXED ? 4'b0001 : 4'b1000);
      @(posedge clk);
      @(negedge clk);
      checkOutput("refill_valid", rsp_valid, 1);
      checkOutput("refill_id", rsp_id, FIXED ? 0 : 3);
      checkOutput("refill_data", rsp_data, FIXED ? 32'd0 : 32'd6);
      @(posedge clk); #1;
      req_valid = '0;

      // Corner opcodes
      runSingle(0, 4'h7, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0);
      runSingle(3, 4'hC, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1);
      runSingle(2, 4'h4, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      checkOutput("sltu_flags", rsp_flags, 5'b10001);

      // Reset while stalled discards the held result and rewinds the pointer
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      driveReq(2, 4'h0, 32'd10, 32'd20);
      req_valid[2] = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      checkOutput("stallrst_valid", rsp_valid, 1);
      checkOutput("stallrst_data", rsp_data, 32'd30);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      req_valid = '1;
      @(negedge clk);
      checkOutput("postrst_valid", rsp_valid, 0);
      checkOutput("postrst_data", rsp_data, 0);
      checkOutput("postrst_grant", req_ready, 4'b0001);

      applyStimulus(3000);

      @(negedge clk);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
